number_ascii_sender: RTL and testbench

Transmit-side companion to the UART number receiver. Takes a WIDTH-bit value from the RISC-V shell and converts it to decimal ASCII with double-dabble. Emits the characters one byte at a time into the Serial transmitter through its send/busy handshake, followed by a terminator byte. It sits between the processor's memory-output word and the Serial block's send inputs, and replaces ad-hoc hex dumping.

---
 rtl/number_ascii_sender.sv | 216 +++++++++++++++++++++
 tb/tb_number_ascii_sender.sv | 330 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/number_ascii_sender.sv
// number_ascii_sender: converts a WIDTH-bit value to decimal ASCII with
// double-dabble. It sends the characters one byte at a time to the Serial
// transmitter over its send/busy handshake, then sends a terminator byte.
//   i_Clk, i_Rst        clock, synchronous active-high reset
//   i_start, i_number   print request (sampled in IDLE) and the value to print
//   i_txd_busy          Serial transmitter busy
//   o_tx_data           ASCII byte; held from its strobe until the next strobe
//   o_send_to_computer  one-cycle send strobe
//   o_busy, o_done      operation in progress / one-cycle completion pulse
module number_ascii_sender #(
  parameter int unsigned WIDTH       = 32,
  parameter int unsigned SIGNED      = 1,
  parameter logic [7:0]  TERM_CHAR   = 8'h0A,
  parameter int unsigned ACK_TIMEOUT = 4
) (
  input  logic             i_Clk,
  input  logic             i_Rst,
  input  logic             i_start,
  input  logic [WIDTH-1:0] i_number,
  input  logic             i_txd_busy,
  output logic [7:0]       o_tx_data,
  output logic             o_send_to_computer,
  output logic             o_busy,
  output logic             o_done
);

  // Digit count of 2^WIDTH-1 is floor(WIDTH*log10(2))+1.
  localparam int unsigned NDIG    = (WIDTH * 30103) / 100000 + 1;
  localparam int unsigned BCD_W   = 4 * NDIG;
  localparam int unsigned IDX_W   = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam int unsigned CNT_MAX = (WIDTH > ACK_TIMEOUT) ? WIDTH : ACK_TIMEOUT;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_CONVERT, S_SCAN, S_SIGN, S_DIGIT, S_TERM, S_DONE
  } state_e;

  typedef enum logic [1:0] {
    P_SEND, P_WAIT_ACK, P_WAIT_DONE
  } phase_e;

  state_e             state_q, state_d;
  phase_e             phase_q, phase_d;
  logic [BCD_W-1:0]   bcd_q, bcd_d;
  logic [WIDTH-1:0]   mag_q, mag_d;
  logic               neg_q, neg_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [7:0]         tx_data_q, tx_data_d;
  logic               send_q, send_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  logic [BCD_W-1:0]   bcd_adj;
  logic [3:0]         cur_digit;
  logic [7:0]         cur_char;
  logic               char_done;

  // Next-state and output logic.
  always_comb begin
    state_d   = state_q;
    phase_d   = phase_q;
    bcd_d     = bcd_q;
    mag_d     = mag_q;
    neg_d     = neg_q;
    idx_d     = idx_q;
    cnt_d     = cnt_q;
    tx_data_d = tx_data_q;
    send_d    = 1'b0;
    busy_d    = busy_q;
    done_d    = 1'b0;
    char_done = 1'b0;
    cur_digit = bcd_q[{idx_q, 2'b00} +: 4];

    // Add-3 correction applied to every BCD nibble before each shift.
    bcd_adj = bcd_q;
    for (int i = 0; i < int'(NDIG); i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) begin
        bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
      end
    end

    case (state_q)
      S_SIGN:  cur_char = 8'h2D;
      S_DIGIT: cur_char = 8'h30 + {4'b0000, cur_digit};
      default: cur_char = TERM_CHAR;
    endcase

    case (state_q)
      S_IDLE: begin
        if (i_start) begin
          busy_d  = 1'b1;
          state_d = S_CONVERT;
          cnt_d   = '0;
          bcd_d   = '0;
          // The magnitude of the most-negative value still fits in WIDTH unsigned bits.
          if (SIGNED != 0 && i_number[WIDTH-1]) begin
            neg_d = 1'b1;
            mag_d = ~i_number + WIDTH'(1);
          end else begin
            neg_d = 1'b0;
            mag_d = i_number;
          end
        end
      end

      S_CONVERT: begin
        bcd_d = {bcd_adj[BCD_W-2:0], mag_q[WIDTH-1]};
        mag_d = mag_q << 1;
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
          state_d = S_SCAN;
          idx_d   = IDX_W'(NDIG - 1);
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      // Skip leading zeros; digit 0 is always printed.
      S_SCAN: begin
        if (idx_q != '0 && cur_digit == 4'd0) begin
          idx_d = idx_q - IDX_W'(1);
        end else begin
          state_d = neg_q ? S_SIGN : S_DIGIT;
          phase_d = P_SEND;
        end
      end

      S_SIGN, S_DIGIT, S_TERM: begin
        case (phase_q)
          P_SEND: begin
            if (!i_txd_busy) begin
              tx_data_d = cur_char;
              send_d    = 1'b1;
              phase_d   = P_WAIT_ACK;
              cnt_d     = '0;
            end
          end
          // Give up on the acknowledge after ACK_TIMEOUT cycles.
          P_WAIT_ACK: begin
            if (i_txd_busy) begin
              phase_d = P_WAIT_DONE;
            end else if (cnt_q == CNT_W'(ACK_TIMEOUT - 1)) begin
              char_done = 1'b1;
            end else begin
              cnt_d = cnt_q + CNT_W'(1);
            end
          end
          P_WAIT_DONE: begin
            if (!i_txd_busy) begin
              char_done = 1'b1;
            end
          end
          default: phase_d = P_SEND;
        endcase

        // Move to the next character in the sequence.
        if (char_done) begin
          phase_d = P_SEND;
          case (state_q)
            S_SIGN: state_d = S_DIGIT;
            S_DIGIT: begin
              if (idx_q == '0) begin
                state_d = S_TERM;
              end else begin
                idx_d = idx_q - IDX_W'(1);
              end
            end
            default: begin
              state_d = S_DONE;
              busy_d  = 1'b0;
              done_d  = 1'b1;
            end
          endcase
        end
      end

      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State and output registers.
  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      state_q   <= S_IDLE;
      phase_q   <= P_SEND;
      bcd_q     <= '0;
      mag_q     <= '0;
      neg_q     <= 1'b0;
      idx_q     <= '0;
      cnt_q     <= '0;
      tx_data_q <= '0;
      send_q    <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      phase_q   <= phase_d;
      bcd_q     <= bcd_d;
      mag_q     <= mag_d;
      neg_q     <= neg_d;
      idx_q     <= idx_d;
      cnt_q     <= cnt_d;
      tx_data_q <= tx_data_d;
      send_q    <= send_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign o_tx_data          = tx_data_q;
  assign o_send_to_computer = send_q;
  assign o_busy             = busy_q;
  assign o_done             = done_q;

endmodule

// File: tb/tb_number_ascii_sender.sv
// Testbench for number_ascii_sender: a signed instance (index 0) and an
// unsigned instance (index 1), each connected to a small Serial busy model.
module tb_number_ascii_sender;

  localparam int unsigned ACK_TO = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start [2]  = '{1'b0, 1'b0};
  logic [31:0] num   [2]  = '{32'd0, 32'd0};
  logic        busy  [2]  = '{1'b0, 1'b0};
  logic [7:0]  data  [2];
  logic        send  [2];
  logic        obusy [2];
  logic        done  [2];

  int    tests = 0;
  int    fails = 0;
  int    cyc = 0;
  int    start_cyc = 0;
  bit    hold_busy = 1'b0;
  bit    never_ack = 1'b0;
  int    bcnt      [2] = '{0, 0};
  string got       [2];
  int    nstrobe   [2] = '{0, 0};
  int    ndone     [2] = '{0, 0};
  bit    last_send [2] = '{1'b0, 1'b0};
  int    last_cyc  [2] = '{0, 0};
  int    first_cyc [2] = '{0, 0};
  int    min_gap   [2] = '{0, 0};
  int    max_gap   [2] = '{0, 0};
  int    long_strobe = 0;

  number_ascii_sender #(.WIDTH(32), .SIGNED(1), .TERM_CHAR(8'h0A), .ACK_TIMEOUT(ACK_TO)) u_s (
    .i_Clk(clk), .i_Rst(rst), .i_start(start[0]), .i_number(num[0]), .i_txd_busy(busy[0]),
    .o_tx_data(data[0]), .o_send_to_computer(send[0]), .o_busy(obusy[0]), .o_done(done[0])
  );

  number_ascii_sender #(.WIDTH(32), .SIGNED(0), .TERM_CHAR(8'h0A), .ACK_TIMEOUT(ACK_TO)) u_u (
    .i_Clk(clk), .i_Rst(rst), .i_start(start[1]), .i_number(num[1]), .i_txd_busy(busy[1]),
    .o_tx_data(data[1]), .o_send_to_computer(send[1]), .o_busy(obusy[1]), .o_done(done[1])
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Serial model: busy for 10 cycles after each strobe; records bytes and timing.
  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (send[k] && !never_ack) bcnt[k] = 10;
      else if (bcnt[k] != 0) bcnt[k] = bcnt[k] - 1;
      busy[k] = hold_busy || (bcnt[k] != 0);
      if (send[k]) begin
        if (last_send[k]) begin
          long_strobe = long_strobe + 1;
        end else begin
          if (nstrobe[k] == 0) begin
            first_cyc[k] = cyc;
          end else begin
            if (cyc - last_cyc[k] < min_gap[k]) min_gap[k] = cyc - last_cyc[k];
            if (cyc - last_cyc[k] > max_gap[k]) max_gap[k] = cyc - last_cyc[k];
          end
          last_cyc[k] = cyc;
          nstrobe[k]  = nstrobe[k] + 1;
          got[k]      = {got[k], $sformatf("%02x ", data[k])};
        end
      end
      last_send[k] = send[k];
      if (done[k]) ndone[k] = ndone[k] + 1;
    end
  end

  function automatic string hexstr(input string s);
    string r;
    r = "";
    for (int i = 0; i < s.len(); i++) r = {r, $sformatf("%02x ", s[i])};
    return r;
  endfunction

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic kick(input int k, input logic [31:0] n);
    got[k]     = "";
    nstrobe[k] = 0;
    min_gap[k] = 1000000;
    max_gap[k] = 0;
    num[k]     = n;
    start[k]   = 1'b1;
    tick();
    start_cyc  = cyc;
    start[k]   = 1'b0;
  endtask

  task automatic wait_done(input int k, output bit to);
    int d0;
    d0 = ndone[k];
    to = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      if (ndone[k] != d0) begin
        to = 1'b0;
        break;
      end
      tick();
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    tick(3);
    for (int k = 0; k < 2; k++) begin
      tests++;
      if ({send[k], obusy[k], done[k], data[k]} !== 11'b0) begin
        fails++;
        $display("FAIL reset_outputs[%0d]: got send=%b busy=%b done=%b data=%h, expected all 0",
                 k, send[k], obusy[k], done[k], data[k]);
      end
    end
    rst = 1'b0;
    tick(2);
  endtask

  task automatic test_zero;
    bit to;
    int d0;
    d0 = ndone[0];
    kick(0, 32'd0);
    wait_done(0, to);
    tests++;
    if (to || got[0] != hexstr("0\n")) begin
      fails++;
      $display("FAIL zero_bytes: got '%s' timeout=%0d, expected '%s'", got[0], to, hexstr("0\n"));
    end
    tick(5);
    tests++;
    if (ndone[0] - d0 != 1 || obusy[0] !== 1'b0) begin
      fails++;
      $display("FAIL zero_done: got done pulses=%0d busy=%b, expected 1 and 0", ndone[0] - d0, obusy[0]);
    end
  endtask

  task automatic test_1234;
    bit to;
    kick(0, 32'd1234);
    wait_done(0, to);
    tests++;
    if (to || got[0] != hexstr("1234\n")) begin
      fails++;
      $display("FAIL dec_1234: got '%s' timeout=%0d, expected '%s'", got[0], to, hexstr("1234\n"));
    end
    tests++;
    if (first_cyc[0] - start_cyc < 33) begin
      fails++;
      $display("FAIL first_strobe_latency: got %0d cycles, expected >= 33", first_cyc[0] - start_cyc);
    end
    tests++;
    if (min_gap[0] < 11) begin
      fails++;
      $display("FAIL strobe_respects_busy: got min gap %0d, expected >= 11", min_gap[0]);
    end
  endtask

  task automatic test_all_ones;
    bit to;
    kick(0, 32'hFFFF_FFFF);
    wait_done(0, to);
    tests++;
    if (to || got[0] != hexstr("-1\n")) begin
      fails++;
      $display("FAIL signed_all_ones: got '%s' timeout=%0d, expected '%s'", got[0], to, hexstr("-1\n"));
    end
    kick(1, 32'hFFFF_FFFF);
    wait_done(1, to);
    tests++;
    if (to || got[1] != hexstr("4294967295\n")) begin
      fails++;
      $display("FAIL unsigned_all_ones: got '%s' timeout=%0d, expected '%s'", got[1], to, hexstr("4294967295\n"));
    end
  endtask

  task automatic test_most_negative;
    bit to;
    kick(0, 32'h8000_0000);
    wait_done(0, to);
    tests++;
    if (to || got[0] != hexstr("-2147483648\n")) begin
      fails++;
      $display("FAIL most_negative: got '%s' timeout=%0d, expected '%s'", got[0], to, hexstr("-2147483648\n"));
    end
    tests++;
    if (nstrobe[0] != 12) begin
      fails++;
      $display("FAIL most_negative_count: got %0d strobes, expected 12", nstrobe[0]);
    end
    kick(1, 32'h8000_0000);
    wait_done(1, to);
    tests++;
    if (to || got[1] != hexstr("2147483648\n")) begin
      fails++;
      $display("FAIL unsigned_msb: got '%s' timeout=%0d, expected '%s'", got[1], to, hexstr("2147483648\n"));
    end
  endtask

  task automatic test_no_ack;
    bit to;
    never_ack = 1'b1;
    tick(2);
    kick(0, 32'd42);
    wait_done(0, to);
    tests++;
    if (to || got[0] != hexstr("42\n")) begin
      fails++;
      $display("FAIL no_ack_bytes: got '%s' timeout=%0d, expected '%s'", got[0], to, hexstr("42\n"));
    end
    tests++;
    if (min_gap[0] < int'(ACK_TO) || max_gap[0] > int'(ACK_TO) + 2) begin
      fails++;
      $display("FAIL no_ack_gap: got gaps %0d..%0d, expected %0d..%0d",
               min_gap[0], max_gap[0], ACK_TO, ACK_TO + 2);
    end
    never_ack = 1'b0;
  endtask

  task automatic test_busy_held;
    bit to;
    hold_busy = 1'b1;
    tick(2);
    kick(0, 32'd7);
    tick(80);
    tests++;
    if (nstrobe[0] != 0 || obusy[0] !== 1'b1) begin
      fails++;
      $display("FAIL busy_held_no_strobe: got strobes=%0d busy=%b, expected 0 and 1", nstrobe[0], obusy[0]);
    end
    hold_busy = 1'b0;
    wait_done(0, to);
    tests++;
    if (to || got[0] != hexstr("7\n")) begin
      fails++;
      $display("FAIL busy_held_bytes: got '%s' timeout=%0d, expected '%s'", got[0], to, hexstr("7\n"));
    end
  endtask

  task automatic test_ignore_start;
    bit to;
    int d0;
    d0 = ndone[0];
    kick(0, 32'd987);
    for (int i = 0; i < 300 && nstrobe[0] < 1; i++) tick();
    num[0]   = 32'd5;
    start[0] = 1'b1;
    tick();
    start[0] = 1'b0;
    wait_done(0, to);
    tests++;
    if (to || got[0] != hexstr("987\n")) begin
      fails++;
      $display("FAIL ignore_start_bytes: got '%s' timeout=%0d, expected '%s'", got[0], to, hexstr("987\n"));
    end
    tick(3);
    tests++;
    if (ndone[0] - d0 != 1) begin
      fails++;
      $display("FAIL ignore_start_done: got %0d done pulses, expected 1", ndone[0] - d0);
    end
  endtask

  task automatic test_reset_mid;
    bit to;
    kick(0, 32'd987);
    for (int i = 0; i < 300 && nstrobe[0] < 2; i++) tick();
    rst = 1'b1;
    tick();
    tests++;
    if ({send[0], obusy[0], done[0], data[0]} !== 11'b0) begin
      fails++;
      $display("FAIL reset_mid_outputs: got send=%b busy=%b done=%b data=%h, expected all 0",
               send[0], obusy[0], done[0], data[0]);
    end
    rst = 1'b0;
    tick(150);
    tests++;
    if (nstrobe[0] != 2 || got[0] != hexstr("98")) begin
      fails++;
      $display("FAIL reset_mid_abort: got %0d strobes '%s', expected 2 '%s'", nstrobe[0], got[0], hexstr("98"));
    end
    kick(0, 32'd56);
    wait_done(0, to);
    tests++;
    if (to || got[0] != hexstr("56\n")) begin
      fails++;
      $display("FAIL after_reset_bytes: got '%s' timeout=%0d, expected '%s'", got[0], to, hexstr("56\n"));
    end
  endtask

  task automatic test_strobe_width;
    tests++;
    if (long_strobe != 0) begin
      fails++;
      $display("FAIL strobe_width: got %0d multi-cycle strobes, expected 0", long_strobe);
    end
  endtask

  initial begin
    test_reset();
    test_zero();
    test_1234();
    test_all_ones();
    test_most_negative();
    test_no_ack();
    test_busy_held();
    test_ignore_start();
    test_reset_mid();
    test_strobe_width();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got time limit, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
